// File: rtl/score_display_scanner.sv
// score_display_scanner
// Converts a 14-bit game score (clamped to 9999) into four BCD digits with an
// iterative double-dabble engine, then time-multiplexes the digits onto one
// shared 4-bit digit bus with matching active-low anode enables.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits;
// the ones digit is always lit).
`timescale 1ns/1ps

module score_display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] score,
  input  logic        score_valid,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [3:0]  an
);

  localparam int unsigned     CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [13:0]     SCORE_MAX = 14'd9999;
  localparam logic [3:0]      LAST_SHIFT = 4'd13;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [13:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       shift_cnt_q, shift_cnt_d;
  logic [15:0]      disp_q, disp_d;
  logic [13:0]      pend_val_q, pend_val_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] div_cnt_q;
  logic [1:0]       idx_q;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       an_q, an_d;

  logic [13:0]      score_clamped;
  logic [15:0]      bcd_adj;
  logic             blank;

  assign score_clamped = (score > SCORE_MAX) ? SCORE_MAX : score;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                    : bcd_q[4*i +: 4];
    end
  end

  // Conversion FSM next-state, datapath and pending-request bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    shift_cnt_d = shift_cnt_q;
    disp_d      = disp_q;
    pend_val_d  = pend_val_q;
    pending_d   = pending_q;

    case (state_q)
      S_IDLE: begin
        if (score_valid) begin
          bin_d       = score_clamped;
          bcd_d       = '0;
          shift_cnt_d = '0;
          state_d     = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        shift_cnt_d    = shift_cnt_q + 4'd1;
        if (shift_cnt_q == LAST_SHIFT) state_d = S_LOAD;
      end
      S_LOAD: begin
        disp_d = bcd_q;
        if (pending_q) begin
          bin_d       = pend_val_q;
          bcd_d       = '0;
          shift_cnt_d = '0;
          pending_d   = 1'b0;
          state_d     = S_CONVERT;
        end else if (score_valid) begin
          // A request arriving in the final busy cycle chains straight on,
          // otherwise it would sit in the pending slot with the FSM idle.
          bin_d       = score_clamped;
          bcd_d       = '0;
          shift_cnt_d = '0;
          state_d     = S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Requests while busy park in the pending slot; the latest one wins.
    if (score_valid && (state_q == S_CONVERT || (state_q == S_LOAD && pending_q))) begin
      pend_val_d = score_clamped;
      pending_d  = 1'b1;
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      // NOTE: the display register is reset too, so a reset mid-conversion shows 0000.
      disp_q      <= '0;
      pend_val_q  <= '0;
      pending_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      shift_cnt_q <= shift_cnt_d;
      disp_q      <= disp_d;
      pend_val_q  <= pend_val_d;
      pending_q   <= pending_d;
    end
  end

  // Refresh divider and digit index; the index advances on each divider wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
    end else if (div_cnt_q == CNT_MAX) begin
      div_cnt_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      div_cnt_q <= div_cnt_q + CNT_W'(1);
    end
  end

  // Select the nibble and anode for the current index, with optional blanking.
  always_comb begin
    case (idx_q)
      2'd1:    digit_d = disp_q[7:4];
      2'd2:    digit_d = disp_q[11:8];
      2'd3:    digit_d = disp_q[15:12];
      default: digit_d = disp_q[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd1:    blank = (disp_q[15:4]  == 12'd0);
      2'd2:    blank = (disp_q[15:8]  == 8'd0);
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    an_d = blank ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  // Register digit and anode together so they can never be skewed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
      an_q    <= 4'b1111;
    end else begin
      digit_q <= digit_d;
      an_q    <= an_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign digit = digit_q;
  assign an    = an_q;

endmodule
